spi_byte_rx: RTL and testbench



---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_byte_rx.sv | 154 +++++++++++++++
 tb/tb_spi_byte_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI host-link byte engine.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_BYTE_WIDTH = 8;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte engine: MSB-first rx assembly and tx reply shifting,
// driven by system-clock SCLK edge enables.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int BYTE_WIDTH = SPI_BYTE_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  spi_sclk_rising_in,
  input  logic                  spi_sclk_falling_in,
  input  logic                  spi_cs_n_in,
  input  logic                  spi_mosi_in,
  input  logic [BYTE_WIDTH-1:0] tx_data_in,
  output logic                  spi_miso_out,
  output logic [BYTE_WIDTH-1:0] byte_data_out,
  output logic                  byte_rdy_out,
  output logic [CNT_WIDTH-1:0]  byte_cnt_out,
  output logic                  frame_start_out,
  output logic                  frame_end_out
);

  localparam int             BCW      = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BYTE_WIDTH - 1);

  spi_state_e state_q, state_d;
  logic armed_q, armed_d;
  logic frame_start_q, frame_start_d;
  logic frame_end_q, frame_end_d;

  logic [BYTE_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_WIDTH-1:0] byte_data_q, byte_data_d;
  logic                  byte_rdy_q, byte_rdy_d;

  logic [BYTE_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic                  seen_rise_q, seen_rise_d;

  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;

  logic start_w, stop_w, rise_w, fall_w, wrap_w;

  // CS deassertion takes priority over any edge; rising wins over falling.
  always_comb begin
    start_w = (state_q == IDLE) && !spi_cs_n_in && armed_q;
    stop_w  = (state_q == SHIFT) && spi_cs_n_in;
    rise_w  = (state_q == SHIFT) && !spi_cs_n_in && spi_sclk_rising_in;
    fall_w  = (state_q == SHIFT) && !spi_cs_n_in && spi_sclk_falling_in && !spi_sclk_rising_in;
    wrap_w  = rise_w && (bit_cnt_q == BIT_LAST);
  end

  // armed_q blocks a frame from starting until CS has been seen high after
  // reset, so a reset mid-frame cannot resync onto the tail of that frame.
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q | spi_cs_n_in;
    frame_start_d = start_w;
    frame_end_d   = stop_w;
    if (start_w) state_d = SHIFT;
    if (stop_w)  state_d = IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  always_comb begin
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_data_d = byte_data_q;
    byte_rdy_d  = 1'b0;
    if (start_w) begin
      rx_sr_d   = '0;
      bit_cnt_d = '0;
    end else if (rise_w) begin
      rx_sr_d   = {rx_sr_q[BYTE_WIDTH-2:0], spi_mosi_in};
      bit_cnt_d = wrap_w ? '0 : bit_cnt_q + BCW'(1);
      if (wrap_w) begin
        byte_data_d = {rx_sr_q[BYTE_WIDTH-2:0], spi_mosi_in};
        byte_rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      byte_data_q <= '0;
      byte_rdy_q  <= 1'b0;
    end else begin
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_data_q <= byte_data_d;
      byte_rdy_q  <= byte_rdy_d;
    end
  end

  // A falling edge at a byte boundary loads the next reply; the very first
  // falling edge of a frame never does, the frame-start load covers it.
  always_comb begin
    tx_sr_d     = tx_sr_q;
    seen_rise_d = seen_rise_q;
    if (start_w) begin
      tx_sr_d     = tx_data_in;
      seen_rise_d = 1'b0;
    end else if (rise_w) begin
      seen_rise_d = 1'b1;
    end else if (fall_w) begin
      if ((bit_cnt_q == '0) && seen_rise_q) tx_sr_d = tx_data_in;
      else                                  tx_sr_d = {tx_sr_q[BYTE_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_sr_q     <= '0;
      seen_rise_q <= 1'b0;
    end else begin
      tx_sr_q     <= tx_sr_d;
      seen_rise_q <= seen_rise_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (start_w)     byte_cnt_d = '0;
    else if (wrap_w) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) byte_cnt_q <= '0;
    else        byte_cnt_q <= byte_cnt_d;
  end

  assign spi_miso_out    = (state_q == SHIFT) && tx_sr_q[BYTE_WIDTH-1];
  assign byte_data_out   = byte_data_q;
  assign byte_rdy_out    = byte_rdy_q;
  assign byte_cnt_out    = byte_cnt_q;
  assign frame_start_out = frame_start_q;
  assign frame_end_out   = frame_end_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: reset, framing, rx bytes, MISO reply, abort, counter wrap.
module tb_spi_byte_rx;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       rise = 1'b0, fall = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic        miso, rdy, fs, fe;
  logic [7:0]  data;
  logic [15:0] cnt;
  logic        miso2, rdy2, fs2, fe2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  int n_pass = 0, n_total = 0;
  int fs_n = 0;
  logic [7:0]  rdy_data[$];
  logic [15:0] rdy_cnt[$];
  logic [1:0]  rdy_cnt2[$];
  logic [7:0]  rdy_data2[$];
  logic [15:0] miso_word;

  always #5 clk_in = ~clk_in;

  spi_byte_rx #(.BYTE_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_sclk_rising_in(rise), .spi_sclk_falling_in(fall),
    .spi_cs_n_in(cs_n), .spi_mosi_in(mosi), .tx_data_in(tx_data),
    .spi_miso_out(miso), .byte_data_out(data), .byte_rdy_out(rdy),
    .byte_cnt_out(cnt), .frame_start_out(fs), .frame_end_out(fe)
  );

  spi_byte_rx #(.BYTE_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_sclk_rising_in(rise), .spi_sclk_falling_in(fall),
    .spi_cs_n_in(cs_n), .spi_mosi_in(mosi), .tx_data_in(tx_data),
    .spi_miso_out(miso2), .byte_data_out(data2), .byte_rdy_out(rdy2),
    .byte_cnt_out(cnt2), .frame_start_out(fs2), .frame_end_out(fe2)
  );

  always @(negedge clk_in) begin
    if (rdy) begin
      rdy_data.push_back(data);
      rdy_cnt.push_back(cnt);
    end
    if (rdy2) begin
      rdy_data2.push_back(data2);
      rdy_cnt2.push_back(cnt2);
    end
    if (fs) fs_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One SCLK period = 4 system clocks: rise, gap, fall, gap.
  task automatic send_bit(input logic b);
    miso_word = {miso_word[14:0], miso};
    rise = 1'b1; mosi = b; cyc();
    rise = 1'b0; cyc();
    fall = 1'b1; cyc();
    fall = 1'b0; cyc();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  int fs_before;
  logic [1:0] exp_wrap [5];

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    chk("rst_fe", {31'd0, fe}, 32'd0);
    rst_in = 1'b0; cyc(); cyc();

    // Reset mid-frame
    tx_data = 8'hFF;
    cs_n = 1'b0; cyc();
    chk("mid_fs", {31'd0, fs}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("mid_miso_before", {31'd0, miso}, 32'd1);
    rst_in = 1'b1; cyc();
    chk("mid_rst_miso", {31'd0, miso}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt}, 32'd0);
    rst_in = 1'b0; cyc();
    fs_before = fs_n;
    rdy_data.delete(); rdy_cnt.delete();
    send_byte(8'hA5);
    chk("mid_no_rdy", rdy_data.size(), 32'd0);
    chk("mid_no_fs", fs_n, fs_before);
    chk("mid_idle_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b1; cyc();
    chk("mid_no_fe", {31'd0, fe}, 32'd0);
    cyc();

    // Single byte
    tx_data = 8'h00;
    cs_n = 1'b0; cyc();
    chk("single_fs", {31'd0, fs}, 32'd1);
    cyc();
    chk("single_fs_pulse", {31'd0, fs}, 32'd0);
    send_byte(8'hA5);
    chk("single_n", rdy_data.size(), 32'd1);
    chk("single_data", {24'd0, rdy_data[0]}, 32'hA5);
    chk("single_cnt", {16'd0, rdy_cnt[0]}, 32'd1);
    cs_n = 1'b1; cyc();
    chk("single_fe", {31'd0, fe}, 32'd1);
    cyc();
    chk("single_fe_pulse", {31'd0, fe}, 32'd0);

    // Burst
    cs_n = 1'b0; cyc(); cyc();
    rdy_data.delete(); rdy_cnt.delete();
    send_byte(8'h01); send_byte(8'h80); send_byte(8'hFF);
    chk("burst_n", rdy_data.size(), 32'd3);
    chk("burst_d0", {24'd0, rdy_data[0]}, 32'h01);
    chk("burst_d1", {24'd0, rdy_data[1]}, 32'h80);
    chk("burst_d2", {24'd0, rdy_data[2]}, 32'hFF);
    chk("burst_c0", {16'd0, rdy_cnt[0]}, 32'd1);
    chk("burst_c1", {16'd0, rdy_cnt[1]}, 32'd2);
    chk("burst_c2", {16'd0, rdy_cnt[2]}, 32'd3);
    cs_n = 1'b1; cyc(); cyc(); cyc();
    chk("burst_hold_data", {24'd0, data}, 32'hFF);
    chk("burst_hold_cnt", {16'd0, cnt}, 32'd3);

    // MISO reply
    tx_data = 8'h3C;
    cs_n = 1'b0; cyc();
    tx_data = 8'hC3;
    miso_word = 16'h0;
    send_byte(8'h00); send_byte(8'h00);
    chk("miso_stream", {16'd0, miso_word}, 32'h3CC3);
    chk("miso_reload", {31'd0, miso}, 32'd1);
    cs_n = 1'b1; cyc();
    chk("miso_idle", {31'd0, miso}, 32'd0);
    cyc();

    // Aborted byte after 5 bits
    cs_n = 1'b0; cyc();
    rdy_data.delete(); rdy_cnt.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    cs_n = 1'b1; cyc();
    chk("abort_fe", {31'd0, fe}, 32'd1);
    chk("abort_no_rdy", rdy_data.size(), 32'd0);
    cyc();

    // CS rise together with the 8th rising enable: edge ignored
    cs_n = 1'b0; cyc();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    cs_n = 1'b1; rise = 1'b1; mosi = 1'b1; cyc();
    rise = 1'b0;
    chk("csrise_fe", {31'd0, fe}, 32'd1);
    cyc();
    chk("csrise_no_rdy", rdy_data.size(), 32'd0);

    // Next frame decodes cleanly, count restarts
    cs_n = 1'b0; cyc();
    send_byte(8'h5A);
    chk("after_abort_n", rdy_data.size(), 32'd1);
    chk("after_abort_data", {24'd0, rdy_data[0]}, 32'h5A);
    chk("after_abort_cnt", {16'd0, rdy_cnt[0]}, 32'd1);
    cs_n = 1'b1; cyc(); cyc();

    // Counter wrap on the 2-bit instance
    cs_n = 1'b0; cyc();
    chk("wrap_fs2", {31'd0, fs2}, 32'd1);
    rdy_cnt2.delete(); rdy_data2.delete();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3; exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;
    chk("wrap_n", rdy_cnt2.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("wrap_cnt%0d", i), {30'd0, rdy_cnt2[i]}, {30'd0, exp_wrap[i]});
    chk("wrap_last_data", {24'd0, rdy_data2[4]}, 32'h55);
    cs_n = 1'b1; cyc();
    chk("wrap_fe2", {31'd0, fe2}, 32'd1);
    chk("wrap_miso2_idle", {31'd0, miso2}, 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
